// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline sequencer for the 5-stage core. Each cycle it chooses the stall
//   code and per-stage flush strobes for pipeline_reg, and the PC write enable.
//   It resolves I/D cache waits, load-use hazards, taken-branch redirects and
//   halt drain. It also keeps saturating stall/flush performance counters and a
//   sticky D-memory timeout flag.
//
// Parameters
//   CNT_W    width of stall_cnt / flush_cnt (saturating)
//   TIMEOUT  DWAIT cycles without dhit before mem_timeout sets (>= 2)
//
// Ports
//   CLK, nRST            clock, asynchronous active-low reset
//   ihit                 icache returns an instruction this cycle
//   dhit                 dcache completes the EX/MEM access this cycle
//   exmem_dmemREN/WEN    EX/MEM holds a load / store
//   exmem_branch_taken   branch/jump resolved taken in MEM
//   idex_dmemREN         ID/EX instruction is a load
//   idex_rd              ID/EX destination register
//   ifid_rs, ifid_rt     IF/ID source registers
//   memwb_halt           HALT in MEM/WB
//   pipe_stall           stall code (3 bits, encoding below)
//   *_FLUSH              bubble strobes; memwb_FLUSH is always 0
//   pc_WEN               PC load enable
//   halt                 registered, core halted
//   mem_timeout          registered, sticky, D access exceeded TIMEOUT
//   stall_cnt, flush_cnt performance counters
//
// Stall code encoding (must match pipeline_reg):
//   0 NO_STALL, 1 FULL_STALL, 2 IFID_STALL, 3 IDEX_STALL, 4 EXMEM_STALL.
//   EXMEM_STALL is reserved and never produced here.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             exmem_dmemREN,
   input  logic             exmem_dmemWEN,
   input  logic             exmem_branch_taken,
   input  logic             idex_dmemREN,
   input  logic [4:0]       idex_rd,
   input  logic [4:0]       ifid_rs,
   input  logic [4:0]       ifid_rt,
   input  logic             memwb_halt,
   output logic [2:0]       pipe_stall,
   output logic             ifid_FLUSH,
   output logic             idex_FLUSH,
   output logic             exmem_FLUSH,
   output logic             memwb_FLUSH,
   output logic             pc_WEN,
   output logic             halt,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [2:0] NO_STALL   = 3'd0;
   localparam logic [2:0] FULL_STALL = 3'd1;
   localparam logic [2:0] IFID_STALL = 3'd2;
   localparam logic [2:0] IDEX_STALL = 3'd3;

   localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;

   state_t        state, nxt;
   logic [WW-1:0] wait_cnt;
   logic          dreq, lu, redirect;

   assign dreq = exmem_dmemREN | exmem_dmemWEN;
   assign lu   = idex_dmemREN & (idex_rd != 5'd0) &
                 ((idex_rd == ifid_rs) | (idex_rd == ifid_rt));

   assign memwb_FLUSH = 1'b0;

   // Priority decode. Only the redirect row raises flushes, so every
   // FULL_STALL row leaves all flush strobes low.
   always_comb begin
      pipe_stall  = NO_STALL;
      ifid_FLUSH  = 1'b0;
      idex_FLUSH  = 1'b0;
      exmem_FLUSH = 1'b0;
      pc_WEN      = 1'b0;
      redirect    = 1'b0;
      nxt         = state;
      if (state == HALTED) begin
         pipe_stall = FULL_STALL;
      end else if (memwb_halt) begin
         pipe_stall = FULL_STALL;
         nxt        = HALTED;
      end else if (dreq && !dhit) begin
         pipe_stall = FULL_STALL;
         nxt        = DWAIT;
      end else begin
         // Leaving DWAIT (dhit or request dropped) re-evaluates the same rows
         // as RUN, so the pipe advances in the dhit cycle itself.
         nxt = RUN;
         if (exmem_branch_taken) begin
            // Redirect even on an imiss; squashes the load-use victim too.
            redirect    = 1'b1;
            ifid_FLUSH  = 1'b1;
            idex_FLUSH  = 1'b1;
            exmem_FLUSH = 1'b1;
            pc_WEN      = 1'b1;
            pipe_stall  = ihit ? NO_STALL : IFID_STALL;
         end else if (!ihit) begin
            pipe_stall = IFID_STALL;
         end else if (lu) begin
            pipe_stall = IDEX_STALL;
         end else begin
            pc_WEN = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state       <= RUN;
         halt        <= 1'b0;
         mem_timeout <= 1'b0;
         wait_cnt    <= '0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else begin
         state <= nxt;
         // HALTED is absorbing, so halt simply tracks the next state.
         halt  <= (nxt == HALTED);

         if (state != DWAIT && nxt == DWAIT)
            wait_cnt <= '0;
         else if (state == DWAIT && nxt == DWAIT && wait_cnt != WAIT_LAST)
            wait_cnt <= wait_cnt + WW'(1);

         // Flag only; the pipeline keeps waiting for dhit.
         if (state == DWAIT && nxt == DWAIT && wait_cnt == WAIT_LAST)
            mem_timeout <= 1'b1;

         if (state != HALTED && pipe_stall != NO_STALL && !(&stall_cnt))
            stall_cnt <= stall_cnt + CNT_W'(1);

         if (redirect && !(&flush_cnt))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule
